// File: rtl/pwm_pkg.sv
// Shared types and constants for the multi-channel PWM block.
// Latency: none (package only); backpressure: none.
package pwm_pkg;

  typedef enum logic {
    PWM_EDGE   = 1'b0,
    PWM_CENTER = 1'b1
  } pwm_mode_e;

  typedef enum logic {
    CNT_UP   = 1'b0,
    CNT_DOWN = 1'b1
  } cnt_dir_e;

  localparam int unsigned PCT_DIV = 100;

endpackage

// File: rtl/pwm_duty_scale.sv
// Scales a duty code onto the period and clamps it to the percent window.
// Latency: combinational; backpressure: none.
module pwm_duty_scale
  import pwm_pkg::*;
#(
  parameter int WIDTH       = 12,
  parameter int DUTY_WIDTH  = 8,
  parameter int MIN_PERCENT = 0,
  parameter int MAX_PERCENT = 100
) (
  input  logic [DUTY_WIDTH-1:0] duty_i,
  input  logic [WIDTH-1:0]      period_i,
  output logic [WIDTH-1:0]      duty_o
);

  // One common width wide enough for both the duty product and the percent product.
  localparam int CW = (DUTY_WIDTH > 7) ? WIDTH + DUTY_WIDTH : WIDTH + 7;
  localparam logic [CW-1:0] FULL = CW'({DUTY_WIDTH{1'b1}});

  logic [CW-1:0] prod;
  logic [CW-1:0] scaled;
  logic [CW-1:0] lo;
  logic [CW-1:0] hi;

  assign prod   = CW'(duty_i) * CW'(period_i);
  assign scaled = prod / FULL;
  assign lo     = (CW'(period_i) * CW'(MIN_PERCENT)) / CW'(PCT_DIV);
  assign hi     = (CW'(period_i) * CW'(MAX_PERCENT)) / CW'(PCT_DIV);

  always_comb begin
    if (scaled < lo) begin
      duty_o = WIDTH'(lo);
    end else if (scaled > hi) begin
      duty_o = WIDTH'(hi);
    end else begin
      duty_o = WIDTH'(scaled);
    end
  end

endmodule

// File: rtl/pwm_multi.sv
// Multi-channel PWM on one shared edge/center counter with period-boundary shadow loads.
// Latency: pwm_o one cycle after counter_o; backpressure: none (free-running).
module pwm_multi
  import pwm_pkg::*;
#(
  parameter int CHANNELS         = 4,
  parameter int WIDTH            = 12,
  parameter int DUTY_WIDTH       = 8,
  parameter int DUTY_MIN_PERCENT = 0,
  parameter int DUTY_MAX_PERCENT = 100
) (
  input  logic                                 clk_i,
  input  logic                                 reset_i,
  input  logic                                 enable_ni,
  input  logic                                 mode_i,
  input  logic [WIDTH-1:0]                     period_i,
  input  logic [CHANNELS-1:0][DUTY_WIDTH-1:0]  duty_i,
  input  logic [CHANNELS-1:0]                  polarity_i,
  output logic [CHANNELS-1:0]                  pwm_o,
  output logic [WIDTH-1:0]                     counter_o,
  output logic                                 period_end_o
);

  logic [WIDTH-1:0]                cnt_q, cnt_d;
  cnt_dir_e                        dir_q, dir_d;
  logic [WIDTH-1:0]                per_q, per_d;
  pwm_mode_e                       mode_q, mode_d;
  logic [CHANNELS-1:0][WIDTH-1:0]  duty_q, duty_d;
  logic [CHANNELS-1:0][WIDTH-1:0]  duty_scaled;
  logic [CHANNELS-1:0]             pwm_q, pwm_d;

  logic             run;
  logic             at_top;
  logic             term;
  logic             load;
  logic [WIDTH-1:0] last;

  for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
    pwm_duty_scale #(
      .WIDTH      (WIDTH),
      .DUTY_WIDTH (DUTY_WIDTH),
      .MIN_PERCENT(DUTY_MIN_PERCENT),
      .MAX_PERCENT(DUTY_MAX_PERCENT)
    ) u_scale (
      .duty_i  (duty_i[k]),
      .period_i(period_i),
      .duty_o  (duty_scaled[k])
    );
  end

  assign run    = !enable_ni && (per_q > WIDTH'(1));
  assign last   = per_q - WIDTH'(1);
  assign at_top = (cnt_q == last);
  // With P=2 in center mode the down leg is empty, so the top itself ends the period.
  assign term   = (mode_q == PWM_EDGE) ? at_top
                : ((cnt_q == WIDTH'(1)) && ((dir_q == CNT_DOWN) || (per_q == WIDTH'(2))));
  assign load   = !run || term;

  always_comb begin
    cnt_d  = cnt_q;
    dir_d  = dir_q;
    per_d  = per_q;
    mode_d = mode_q;
    duty_d = duty_q;
    pwm_d  = polarity_i;

    if (load) begin
      per_d  = period_i;
      mode_d = pwm_mode_e'(mode_i);
      duty_d = duty_scaled;
    end

    // While disabled, park on the terminal value of the shadows being loaded.
    if (enable_ni) begin
      if (period_i < WIDTH'(2)) begin
        cnt_d = '0;
        dir_d = CNT_UP;
      end else if (mode_i) begin
        cnt_d = WIDTH'(1);
        dir_d = CNT_DOWN;
      end else begin
        cnt_d = period_i - WIDTH'(1);
        dir_d = CNT_UP;
      end
    end else if (!run || term || (cnt_q > last)) begin
      cnt_d = '0;
      dir_d = CNT_UP;
    end else if (mode_q == PWM_EDGE) begin
      cnt_d = cnt_q + WIDTH'(1);
    end else if (dir_q == CNT_UP) begin
      if (at_top) begin
        cnt_d = cnt_q - WIDTH'(1);
        dir_d = CNT_DOWN;
      end else begin
        cnt_d = cnt_q + WIDTH'(1);
      end
    end else begin
      cnt_d = cnt_q - WIDTH'(1);
    end

    if (run) begin
      for (int k = 0; k < CHANNELS; k++) begin
        pwm_d[k] = (cnt_q < duty_q[k]) ^ polarity_i[k];
      end
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      cnt_q  <= '0;
      dir_q  <= CNT_UP;
      per_q  <= '0;
      mode_q <= PWM_EDGE;
      duty_q <= '0;
      pwm_q  <= '0;
    end else begin
      cnt_q  <= cnt_d;
      dir_q  <= dir_d;
      per_q  <= per_d;
      mode_q <= mode_d;
      duty_q <= duty_d;
      pwm_q  <= pwm_d;
    end
  end

  assign pwm_o        = pwm_q;
  assign counter_o    = cnt_q;
  assign period_end_o = run && term;

endmodule
